// File: rtl/load_store_unit.sv
// Memory stage: runs one load or store per instruction on a req/ack data bus,
// stalling the CPU until done and returning extended load data or a fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_sign;

  logic        w_access;
  logic        w_fault;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  assign w_access  = mem_read_i | mem_write_i;
  assign w_timeout = (r_cnt == CNT_LAST);

  always_comb begin
    w_fault = 1'b0;
    w_be    = '0;
    w_wdata = wdata_i;
    case (size_i)
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_fault = addr_i[0];
        w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        w_fault = (addr_i[1:0] != 2'b00);
        w_be    = 4'b1111;
      end
      default: w_fault = 1'b1;
    endcase
    if (mem_read_i && mem_write_i) w_fault = 1'b1;
  end

  // Lane shift then width select; word loads never extend so sign is moot.
  always_comb begin
    w_shift = bus_rdata_i >> {r_lane, 3'b000};
    case (r_size)
      2'b00:   w_load = r_sign ? {{24{w_shift[7]}}, w_shift[7:0]}
                               : {24'h0, w_shift[7:0]};
      2'b01:   w_load = r_sign ? {{16{w_shift[15]}}, w_shift[15:0]}
                               : {16'h0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    bus_req_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_access;
        if (w_access) w_next = w_fault ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
        if (bus_ack_i || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt       <= '0;
      r_lane      <= '0;
      r_size      <= '0;
      r_sign      <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_cnt  <= '0;
            r_lane <= addr_i[1:0];
            r_size <= size_i;
            r_sign <= sign_i;
            if (w_fault) begin
              err_o   <= 1'b1;
              rdata_o <= '0;
            end else begin
              bus_we_o    <= mem_write_i;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_be_o    <= w_be;
              bus_wdata_o <= w_wdata;
            end
          end
        end
        S_REQ: begin
          // Ack is checked before the timeout so a last-cycle ack succeeds.
          if (bus_ack_i) begin
            err_o   <= 1'b0;
            rdata_o <= w_load;
          end else if (w_timeout) begin
            err_o   <= 1'b1;
            rdata_o <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
